// File: rtl/instr_stream_encoder_pkg.sv
// Shared types for the instruction stream encoder: RV32I opcodes, immediate
// format selector, session FSM states and error codes.
package instr_stream_encoder_pkg;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;

    typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

    typedef enum logic [1:0] {ENC_IDLE, ENC_RUN, ENC_DONE} enc_state_e;

    typedef enum logic [1:0] {ERR_NONE, ERR_OPCODE, ERR_ALIGN, ERR_FULL} enc_err_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I packer: selects the format from the opcode and assembles
// the instruction word; flags unknown opcodes and odd branch/jump offsets.
module instr_pack
    import instr_stream_encoder_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output imm_sel_e    fmt,
    output logic        illegal,
    output logic        misalign
);

    logic [11:0] imm_i;

    // Shift-immediate forms carry funct7 in the upper immediate bits.
    always_comb begin
        imm_i = imm[11:0];
        if (opcode == OPCODE_ITYPE && (funct3 == 3'b001 || funct3 == 3'b101))
            imm_i = {funct7, imm[4:0]};
    end

    always_comb begin
        word     = '0;
        fmt      = IMM_R;
        illegal  = 1'b0;
        misalign = 1'b0;
        unique case (opcode)
            OPCODE_RTYPE: begin
                fmt  = IMM_R;
                word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            OPCODE_ITYPE, OPCODE_LOAD, OPCODE_JALR: begin
                fmt  = IMM_I;
                word = {imm_i, rs1, funct3, rd, opcode};
            end
            OPCODE_STORE: begin
                fmt  = IMM_S;
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            end
            OPCODE_BRANCH: begin
                fmt      = IMM_B;
                misalign = imm[0];
                word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            end
            OPCODE_LUI, OPCODE_AUIPC: begin
                fmt  = IMM_U;
                word = {imm[31:12], rd, opcode};
            end
            OPCODE_JAL: begin
                fmt      = IMM_J;
                misalign = imm[0];
                word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Session controller: accepts field-level requests, packs them and writes the
// words to consecutive imem slots from a programmed base address.
module instr_stream_encoder
    import instr_stream_encoder_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic [ADDR_W-1:0]              base_addr_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic                           req_last_i,
    input  logic [6:0]                     opcode_i,
    input  logic [2:0]                     funct3_i,
    input  logic [6:0]                     funct7_i,
    input  logic [4:0]                     rd_i,
    input  logic [4:0]                     rs1_i,
    input  logic [4:0]                     rs2_i,
    input  logic [31:0]                    imm_i,
    output logic                           imem_we_o,
    output logic [ADDR_W-1:0]              imem_addr_o,
    output logic [31:0]                    imem_wdata_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [$clog2(DEPTH_WORDS):0]   count_o,
    output logic                           err_o,
    output logic [1:0]                     err_code_o
);

    localparam int CNT_W = $clog2(DEPTH_WORDS) + 1;

    enc_state_e          state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W-1:0]   waddr_reg;
    logic [31:0]         wdata_reg;
    logic                we_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                err_reg;
    enc_err_e            err_code_reg;

    logic [31:0] pack_word;
    imm_sel_e    pack_fmt;
    logic        pack_illegal, pack_misalign;

    logic     req_ready, accept, align_bad, reject, do_write, hit_full;
    enc_err_e err_hit;

    instr_pack u_pack (
        .opcode   (opcode_i),
        .funct3   (funct3_i),
        .funct7   (funct7_i),
        .rd       (rd_i),
        .rs1      (rs1_i),
        .rs2      (rs2_i),
        .imm      (imm_i),
        .word     (pack_word),
        .fmt      (pack_fmt),
        .illegal  (pack_illegal),
        .misalign (pack_misalign)
    );

    always_comb begin
        req_ready = (state_reg == ENC_RUN) && (count_reg < CNT_W'(DEPTH_WORDS));
        accept    = req_valid_i && req_ready;
        align_bad = pack_misalign && (pack_fmt == IMM_B || pack_fmt == IMM_J);
        reject    = pack_illegal || align_bad;
        do_write  = accept && !reject;
        hit_full  = do_write && (count_reg == CNT_W'(DEPTH_WORDS - 1));
        err_hit   = ERR_NONE;
        if (accept && reject)
            err_hit = pack_illegal ? ERR_OPCODE : ERR_ALIGN;
        else if (hit_full && !req_last_i)
            err_hit = ERR_FULL;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ENC_IDLE: if (start_i) state_next = ENC_RUN;
            ENC_RUN:  if ((accept && req_last_i) || hit_full) state_next = ENC_DONE;
            ENC_DONE: state_next = ENC_IDLE;
            default:  state_next = ENC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ENC_IDLE;
            addr_reg     <= '0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            we_reg       <= 1'b0;
            count_reg    <= '0;
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
        end else begin
            state_reg <= state_next;
            we_reg    <= do_write;
            if (state_reg == ENC_IDLE && start_i) begin
                addr_reg     <= {base_addr_i[ADDR_W-1:2], 2'b00};
                count_reg    <= '0;
                err_reg      <= 1'b0;
                err_code_reg <= ERR_NONE;
            end
            if (do_write) begin
                waddr_reg <= addr_reg;
                wdata_reg <= pack_word;
                addr_reg  <= addr_reg + ADDR_W'(4);
                count_reg <= count_reg + CNT_W'(1);
            end
            // Only the first error of a session is reported in the code.
            if (err_hit != ERR_NONE) begin
                err_reg <= 1'b1;
                if (!err_reg) err_code_reg <= err_hit;
            end
        end
    end

    assign req_ready_o  = req_ready;
    assign imem_we_o    = we_reg;
    assign imem_addr_o  = waddr_reg;
    assign imem_wdata_o = wdata_reg;
    assign busy_o       = (state_reg != ENC_IDLE);
    assign done_o       = (state_reg == ENC_DONE);
    assign count_o      = count_reg;
    assign err_o        = err_reg;
    assign err_code_o   = err_code_reg;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder: expected imem writes go into a
// scoreboard queue at accept time and are popped by a write monitor.
module tb_instr_stream_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_last_i = 1'b0;
    logic [6:0]  opcode_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [6:0]  funct7_i = '0;
    logic [4:0]  rd_i = '0, rs1_i = '0, rs2_i = '0;
    logic [31:0] imm_i = '0;
    logic        imem_we_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_wdata_o;
    logic        busy_o, done_o, err_o;
    logic [2:0]  count_o;
    logic [1:0]  err_code_o;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] sb[$];
    logic [31:0] exp_addr = '0;

    instr_stream_encoder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_last_i(req_last_i),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
        .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
        .busy_o(busy_o), .done_o(done_o), .count_o(count_o),
        .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Write monitor: every imem write must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (imem_we_o === 1'b1) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                logic [63:0] e;
                e = sb.pop_front();
                $display("write addr=0x%08h data=0x%08h", imem_addr_o, imem_wdata_o);
                check("wr_addr", imem_addr_o, e[63:32]);
                check("wr_data", imem_wdata_o, e[31:0]);
            end
        end
    end

    task automatic start_session(input logic [31:0] base);
        @(posedge clk); #1;
        start_i = 1'b1;
        base_addr_i = base;
        @(posedge clk); #1;
        start_i = 1'b0;
        exp_addr = {base[31:2], 2'b00};
    endtask

    // Drive one request, wait (bounded) for acceptance, check the N+1 strobe.
    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last,
                        input logic wr, input logic [31:0] word);
        opcode_i = op; funct3_i = f3; funct7_i = f7;
        rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
        req_last_i = last;
        req_valid_i = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready_o) break;
        end
        check("ready_seen", 32'(req_ready_o), 32'd1);
        if (wr) begin
            sb.push_back({exp_addr, word});
            exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        req_last_i = 1'b0;
        check("we_n_plus_1", 32'(imem_we_o), 32'(wr));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 32'(imem_we_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_count", 32'(count_o), 0);
        check("rst_ready", 32'(req_ready_o), 0);
        check("rst_err", {30'd0, err_code_o} | 32'(err_o), 0);
        check("rst_addr", imem_addr_o, 0);
        rst_n = 1'b1;

        // addi x1,x0,5 as a single-word session
        start_session(32'h100);
        check("run_busy", 32'(busy_o), 1);
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b1, 32'h00500093);
        check("addi_done", 32'(done_o), 1);
        check("addi_count", 32'(count_o), 1);
        @(posedge clk); #1;
        check("done_pulse", 32'(done_o), 0);
        check("idle_busy", 32'(busy_o), 0);

        // add ; sw (last), with a start pulse while running that must be ignored
        start_session(32'h100);
        start_i = 1'b1;
        base_addr_i = 32'h900;
        send(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3);
        send(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 1'b1, 32'h0020A423);
        start_i = 1'b0;
        check("stream_done", 32'(done_o), 1);
        check("stream_count", 32'(count_o), 2);

        // B/J/U/shift formats; last on the DEPTH-th word is not a full error
        start_session(32'h200);
        send(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 1'b1, 32'hFE208EE3);
        send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0, 1'b1, 32'h008000EF);
        send(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b1, 32'h123452B7);
        send(7'h13, 3'd5, 7'h20, 5'd2, 5'd1, 5'd0, 32'd5, 1'b1, 1'b1, 32'h4050D113);
        check("fmt_done", 32'(done_o), 1);
        check("fmt_count", 32'(count_o), 4);
        check("fmt_no_err", 32'(err_o), 0);

        // slli packs funct7 into the immediate
        start_session(32'h280);
        send(7'h13, 3'd1, 7'd0, 5'd2, 5'd1, 5'd0, 32'd3, 1'b1, 1'b1, 32'h00309113);

        // Rejects: unknown opcode then misaligned jal as last
        start_session(32'h300);
        send(7'h7F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("rej_err_early", 32'(err_o), 1);
        send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b1, 1'b0, 32'd0);
        check("rej_done", 32'(done_o), 1);
        check("rej_err", 32'(err_o), 1);
        check("rej_code", 32'(err_code_o), 1);
        check("rej_count", 32'(count_o), 0);

        // Full: DEPTH writes without last, unaligned base forced to word
        start_session(32'h403);
        check("start_clr_err", 32'(err_o), 0);
        check("start_clr_code", 32'(err_code_o), 0);
        for (int i = 0; i < DEPTH; i++)
            send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(i), 1'b0, 1'b1,
                 (32'(i) << 20) | 32'h00000093);
        check("full_ready", 32'(req_ready_o), 0);
        check("full_err", 32'(err_o), 1);
        check("full_code", 32'(err_code_o), 3);
        check("full_done", 32'(done_o), 1);
        check("full_count", 32'(count_o), 4);
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        check("full_idle", 32'(busy_o), 0);
        check("full_idle_ready", 32'(req_ready_o), 0);
        @(posedge clk); #1;
        req_valid_i = 1'b0;

        // Address wrap at the top of the address space
        start_session(32'hFFFFFFFC);
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 1'b1, 32'h00100093);
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2, 1'b1, 1'b1, 32'h00200093);

        // Reset mid-stream with valid held
        start_session(32'h500);
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7, 1'b0, 1'b1, 32'h00700093);
        req_valid_i = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_we", 32'(imem_we_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_count", 32'(count_o), 0);
        check("mid_rst_ready", 32'(req_ready_o), 0);
        rst_n = 1'b1;
        req_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
